zmod_adc_capture_v1_0: RTL and testbench

Triggered capture buffer for the ZMOD ADC channel A sample stream. It is the receive-side counterpart of the DAC playback memory: the playback memory is read out to the DAC, and this block writes ADC samples into a circular memory. It keeps a pre-trigger window, freezes after a post-trigger window, and exposes the frozen record on a synchronous read port. It sits between zmod_adc_driver_v1_0 outputs and the debug/readout logic in the 100 MHz domain.

---
 rtl/zmod_adc_capture_v1_0.sv | 189 ++++++++++++++++++
 tb/tb_zmod_adc_capture_v1_0.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_adc_capture_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : zmod_adc_capture_v1_0
// Brief    : Triggered circular capture buffer for the ZMOD ADC channel A
//            stream, with pre-trigger window and frozen-record readout.
//            Optional sample decimation is enabled by ZMOD_CAPTURE_DECIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module zmod_adc_capture_v1_0 #(
    parameter int AW      = 7,
    parameter int PRETRIG = 16,
    parameter int DW      = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] is14_data_a,
`ifdef ZMOD_CAPTURE_DECIM_EN
    input  logic [7:0]           i8_decim,
`endif
    input  logic                 i_arm,
    input  logic                 i_force_trigger,
    input  logic signed [DW-1:0] is14_trig_level,
    input  logic                 i_trig_rising,
    input  logic [AW-1:0]        i7_rd_addr,
    output logic signed [DW-1:0] os14_rd_data,
    output logic                 or_armed,
    output logic                 or_triggered,
    output logic                 or_done,
    output logic [AW-1:0]        or7_trig_ptr
);

    localparam int             c_depth     = 1 << AW;
    localparam logic [AW-1:0]  c_pretrig   = AW'(PRETRIG);
    localparam logic [AW-1:0]  c_pre_last  = AW'(PRETRIG - 1);
    localparam logic [AW-1:0]  c_post_load = AW'(c_depth - PRETRIG - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE_FILL  = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST_FILL = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_pre_cnt;
    logic [AW-1:0]         r_post_cnt;
    logic [AW-1:0]         r_trig_ptr;
    logic signed [DW-1:0]  r_prev;
    logic                  r_prev_valid;
    logic signed [DW-1:0]  r_rd_data;
    logic [AW-1:0]         w_rd_phys;
    logic                  w_accept;
    logic                  w_we;
    logic                  w_trig;
    logic                  w_level_hit;
    logic                  w_arm_ok;

    logic signed [DW-1:0]  r_mem [0:c_depth-1];

`ifdef ZMOD_CAPTURE_DECIM_EN
    logic [7:0] r_decim_cnt;

    assign w_accept = (r_decim_cnt == i8_decim);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_decim_cnt <= '0;
        end else if (i_arm || w_accept) begin
            r_decim_cnt <= '0;
        end else begin
            r_decim_cnt <= r_decim_cnt + 8'd1;
        end
    end
`else
    assign w_accept = 1'b1;
`endif

    assign w_arm_ok = i_arm && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_trig      = 1'b0;
        w_level_hit = 1'b0;
        // The comparison needs a real previous sample; after a PRETRIG=0 arm there is none yet.
        if (r_prev_valid) begin
            if (i_trig_rising) begin
                w_level_hit = (r_prev < is14_trig_level) && (is14_trig_level <= is14_data_a);
            end else begin
                w_level_hit = (r_prev >= is14_trig_level) && (is14_trig_level > is14_data_a);
            end
        end
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_arm) begin
                    w_state_nxt = (PRETRIG == 0) ? S_WAIT_TRIG : S_PRE_FILL;
                end
            end
            S_PRE_FILL: begin
                if (w_accept) begin
                    w_we = 1'b1;
                    if (r_pre_cnt == c_pre_last) begin
                        w_state_nxt = S_WAIT_TRIG;
                    end
                end
            end
            S_WAIT_TRIG: begin
                if (w_accept) begin
                    w_we   = 1'b1;
                    w_trig = i_force_trigger || w_level_hit;
                    if (w_trig) begin
                        w_state_nxt = (c_post_load == '0) ? S_DONE : S_POST_FILL;
                    end
                end
            end
            S_POST_FILL: begin
                // Counter holds the samples still owed after the trigger sample.
                if (w_accept) begin
                    w_we = 1'b1;
                    if (r_post_cnt == AW'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_trig_ptr   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_ok) begin
                r_pre_cnt    <= '0;
                r_prev_valid <= 1'b0;
            end
            if (w_we) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev       <= is14_data_a;
                r_prev_valid <= 1'b1;
                if (r_state == S_PRE_FILL) begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
                if (r_state == S_POST_FILL) begin
                    r_post_cnt <= r_post_cnt - 1'b1;
                end
            end
            if (w_trig) begin
                r_trig_ptr <= r_wr_ptr;
                r_post_cnt <= c_post_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= is14_data_a;
        end
    end

    // Logical index 0 is the oldest sample, PRETRIG places before the trigger.
    assign w_rd_phys = r_trig_ptr - c_pretrig + i7_rd_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_phys];
        end
    end

    assign os14_rd_data = r_rd_data;
    assign or_armed     = (r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG);
    assign or_triggered = (r_state == S_POST_FILL);
    assign or_done      = (r_state == S_DONE);
    assign or7_trig_ptr = r_trig_ptr;

endmodule
`default_nettype wire

// File: tb/tb_zmod_adc_capture_v1_0.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_zmod_adc_capture_v1_0
// Brief    : Directed vectors and capture sequences for zmod_adc_capture_v1_0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zmod_adc_capture_v1_0;

    localparam int AW      = 7;
    localparam int PRETRIG = 16;
    localparam int DW      = 14;
    localparam int DEPTH   = 1 << AW;

    typedef struct {
        int addr;
        int exp_val;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic signed [DW-1:0] data_a = '0;
    logic                 arm = 1'b0;
    logic                 force_trig = 1'b0;
    logic signed [DW-1:0] trig_level = '0;
    logic                 trig_rising = 1'b1;
    logic [AW-1:0]        rd_addr = '0;
    logic signed [DW-1:0] rd_data;
    logic                 armed;
    logic                 triggered;
    logic                 done;
    logic [AW-1:0]        trig_ptr;
`ifdef ZMOD_CAPTURE_DECIM_EN
    logic [7:0]           decim = 8'd0;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int mode    = 0;   // 0 hold, 1 ramp, 2 sine
    int ramp_val = 0;
    int phase    = 0;

    zmod_adc_capture_v1_0 #(.AW(AW), .PRETRIG(PRETRIG), .DW(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .is14_data_a     (data_a),
`ifdef ZMOD_CAPTURE_DECIM_EN
        .i8_decim        (decim),
`endif
        .i_arm           (arm),
        .i_force_trigger (force_trig),
        .is14_trig_level (trig_level),
        .i_trig_rising   (trig_rising),
        .i7_rd_addr      (rd_addr),
        .os14_rd_data    (rd_data),
        .or_armed        (armed),
        .or_triggered    (triggered),
        .or_done         (done),
        .or7_trig_ptr    (trig_ptr)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] sine_at(input int n);
        return DW'($rtoi(4000.0 * $sin(6.283185307179586 * real'(n) / 64.0)));
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            1: begin data_a = DW'(ramp_val); ramp_val++; end
            2: begin data_a = sine_at(phase); phase++; end
            default: ;
        endcase
    endtask

    // which: 0 = triggered, 1 = done
    task automatic wait_flag(input string name, input int which, input int budget, output int cycles);
        cycles = 0;
        while (((which == 0) ? triggered : done) !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        if (((which == 0) ? triggered : done) !== 1'b1) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic read_at(input int addr, output int val);
        rd_addr = AW'(addr);
        tick();
        val = rd_data;
    endtask

    task automatic arm_ramp();
        mode = 1;
        data_a = DW'(-100);
        ramp_val = -99;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        vec_t rb[8];
        int   cyc;
        int   v;
        int   v15;
        int   v16;
        int   ntrig;
        int   bad;

        rb[0] = '{addr: 0,   exp_val: -16};
        rb[1] = '{addr: 1,   exp_val: -15};
        rb[2] = '{addr: 15,  exp_val: -1};
        rb[3] = '{addr: 16,  exp_val: 0};
        rb[4] = '{addr: 17,  exp_val: 1};
        rb[5] = '{addr: 64,  exp_val: 48};
        rb[6] = '{addr: 126, exp_val: 110};
        rb[7] = '{addr: 127, exp_val: 111};

        // Reset held with arm asserted
        rst = 1'b0;
        arm = 1'b1;
        repeat (4) tick();
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_trig_ptr", trig_ptr, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        arm = 1'b0;
        tick();
        check("idle_after_rst", armed, 0);

        // Ramp, rising through 0
        trig_level = '0;
        trig_rising = 1'b1;
        arm_ramp();
        check("ramp_prefill_armed", armed, 1);
        wait_flag("ramp_trig", 0, 300, cyc);
        check("ramp_trig_ptr", trig_ptr, 99);
        check("ramp_post_armed", armed, 0);
        wait_flag("ramp_done", 1, 300, cyc);
        check("ramp_done_latency", cyc, 111);
        for (int i = 0; i < 8; i++) begin
            read_at(rb[i].addr, v);
            check($sformatf("ramp_rd[%0d]", rb[i].addr), v, rb[i].exp_val);
        end
        check("ramp_done_held", done, 1);

        // Sine, falling through 1000; a crossing falls inside the pre-fill window
        mode = 2;
        trig_level = DW'(1000);
        trig_rising = 1'b0;
        data_a = sine_at(19);
        phase = 20;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (20) tick();
        check("sine_no_prefill_trig", triggered, 0);
        check("sine_still_armed", armed, 1);
        ntrig = -1;
        for (int n = 36; n < 200; n++) begin
            if (ntrig < 0 && sine_at(n - 1) >= 1000 && sine_at(n) < 1000) ntrig = n;
        end
        wait_flag("sine_trig", 0, 200, cyc);
        wait_flag("sine_done", 1, 300, cyc);
        read_at(15, v15);
        read_at(16, v16);
        check("sine_rd[15]", v15, sine_at(ntrig - 1));
        check("sine_rd[16]", v16, sine_at(ntrig));
        check("sine_crossing", (v16 <= 1000 && v15 >= 1000) ? 1 : 0, 1);
        read_at(0, v);
        check("sine_rd[0]", v, sine_at(ntrig - 16));
        read_at(127, v);
        check("sine_rd[127]", v, sine_at(ntrig + 111));

        // Constant input, forced trigger
        mode = 0;
        data_a = DW'(500);
        trig_level = '0;
        trig_rising = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (30) tick();
        check("const_armed", armed, 1);
        check("const_no_trig", triggered, 0);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        check("force_triggered", triggered, 1);
        wait_flag("force_done", 1, 300, cyc);
        check("force_done_latency", cyc, 111);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            read_at(i, v);
            if (v != 500) bad++;
        end
        check("const_record_errors", bad, 0);

        // Arm with force together, force held through pre-fill; then reset mid post-fill
        mode = 1;
        data_a = DW'(-100);
        ramp_val = -99;
        arm = 1'b1;
        force_trig = 1'b1;
        tick();
        arm = 1'b0;
        repeat (16) tick();
        force_trig = 1'b0;
        check("arm_force_no_trig", triggered, 0);
        check("arm_force_armed", armed, 1);
        wait_flag("abort_trig", 0, 300, cyc);
        repeat (10) tick();
        check("abort_pre_triggered", triggered, 1);
        rst = 1'b0;
        tick();
        check("abort_triggered", triggered, 0);
        check("abort_armed", armed, 0);
        check("abort_done", done, 0);
        check("abort_trig_ptr", trig_ptr, 0);
        rst = 1'b1;
        tick();
        check("abort_idle", armed, 0);
        arm_ramp();
        wait_flag("rearm_trig", 0, 300, cyc);
        check("rearm_trig_ptr", trig_ptr, 99);
        wait_flag("rearm_done", 1, 300, cyc);
        check("rearm_done_latency", cyc, 111);
        read_at(16, v);
        check("rearm_rd[16]", v, 0);
        read_at(0, v);
        check("rearm_rd[0]", v, -16);

`ifdef ZMOD_CAPTURE_DECIM_EN
        decim = 8'd3;
        arm_ramp();
        wait_flag("decim_trig", 0, 1500, cyc);
        wait_flag("decim_done", 1, 1500, cyc);
        read_at(16, v16);
        read_at(17, v);
        check("decim_step_16_17", v - v16, 4);
        read_at(0, v15);
        read_at(1, v);
        check("decim_step_0_1", v - v15, 4);
        read_at(127, v);
        check("decim_span", v - v15, 4 * 127);
        decim = 8'd0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
